// File: rtl/bus_responder_if.sv
// CPU-side bus, TX stream and interrupt bundle for bus_responder.
// master: CPU/transmitter side; slave: the responder.
interface bus_responder_if;
    logic [15:0] address;
    logic        write;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        hold;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        irq;

    modport master (
        output address, write, data_out, tx_ready,
        input  data_in, hold, tx_valid, tx_data, irq
    );

    modport slave (
        input  address, write, data_out, tx_ready,
        output data_in, hold, tx_valid, tx_data, irq
    );
endinterface

// File: rtl/bus_responder.sv
// Memory-side responder: word RAM, TX byte FIFO, interval timer.
// Ports: clk, reset (async high), bus (slave modport of bus_responder_if).
module bus_responder #(
    parameter int          RAM_ADDR_BITS = 10,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [7:0]  IO_PAGE       = 8'hFF
) (
    input logic             clk,
    input logic             reset,
    bus_responder_if.slave  bus
);
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;
    localparam int RAM_WORDS = 1 << RAM_ADDR_BITS;

    logic [15:0]  r_mem [RAM_WORDS];
    logic [7:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [15:0]   r_reload;
    logic [15:0]   r_counter;
    logic          r_enable;
    logic          r_expired;
    logic [15:0]   r_data_in;

    logic          w_ram_hit;
    logic          w_io_hit;
    logic [1:0]    w_reg;
    logic          w_wr_tx;
    logic          w_wr_status;
    logic          w_wr_reload;
    logic          w_wr_timer;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_push_drop;
    logic          w_expire;
    logic [7:0]    w_cnt8;
    logic [15:0]   w_status;
    logic [15:0]   w_rd_data;

    assign w_ram_hit = (bus.address >> RAM_ADDR_BITS) == 16'd0;
    assign w_io_hit  = (bus.address[15:8] == IO_PAGE)
                    && (bus.address[7:2] == 6'd0);
    assign w_reg     = bus.address[1:0];

    assign w_wr_tx     = bus.write && w_io_hit && (w_reg == 2'd0);
    assign w_wr_status = bus.write && w_io_hit && (w_reg == 2'd1);
    assign w_wr_reload = bus.write && w_io_hit && (w_reg == 2'd2);
    assign w_wr_timer  = bus.write && w_io_hit && (w_reg == 2'd3);

    assign w_full  = r_count == CW'(FIFO_DEPTH);
    assign w_empty = r_count == '0;
    assign w_pop   = !w_empty && bus.tx_ready;
    // A pop on the same edge frees the slot a full FIFO needs.
    assign w_push_ok   = w_wr_tx && (!w_full || w_pop);
    assign w_push_drop = w_wr_tx && w_full && !w_pop;

    assign w_expire = r_enable && (r_counter == 16'd0);

    assign w_cnt8   = 8'(r_count);
    assign w_status = {w_cnt8, 3'b000, r_enable, r_expired,
                       r_overflow, w_full, w_empty};

    always_comb begin
        w_rd_data = '0;
        unique case (1'b1)
            w_ram_hit: w_rd_data = r_mem[bus.address[RAM_ADDR_BITS-1:0]];
            w_io_hit: begin
                unique case (w_reg)
                    2'd0: w_rd_data = '0;
                    2'd1: w_rd_data = w_status;
                    2'd2: w_rd_data = r_reload;
                    2'd3: w_rd_data = r_counter;
                endcase
            end
            default: w_rd_data = '0;
        endcase
    end

    // RAM and FIFO storage are intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (bus.write && w_ram_hit)
            r_mem[bus.address[RAM_ADDR_BITS-1:0]] <= bus.data_out;
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_fifo[r_wr_ptr] <= bus.data_out[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_in <= '0;
        end else begin
            r_data_in <= w_rd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push_ok && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push_ok)
                r_count <= r_count - CW'(1);
            if (w_push_drop)
                r_overflow <= 1'b1;
            else if (w_wr_status && bus.data_out[2])
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reload  <= '0;
            r_counter <= '0;
            r_enable  <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            if (w_wr_timer)
                r_enable <= bus.data_out[0];
            if (w_wr_reload) begin
                r_reload  <= bus.data_out;
                r_counter <= bus.data_out;
            end else if (r_enable) begin
                if (r_counter == 16'd0)
                    r_counter <= r_reload;
                else
                    r_counter <= r_counter - 16'd1;
            end
            // Hardware expiry wins over a same-edge software clear.
            if (w_expire)
                r_expired <= 1'b1;
            else if (w_wr_status && bus.data_out[3])
                r_expired <= 1'b0;
        end
    end

    assign bus.data_in  = r_data_in;
    assign bus.hold     = w_full;
    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign bus.irq      = r_expired;
endmodule
